// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decode-side control/data in, EX-side registered copies out.
interface id_ex_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              id_regwrite;
  logic              id_memtoreg;
  logic              id_memwrite;
  logic              id_alusrc;
  logic              id_regdst;
  logic              id_jump;
  logic              id_branch;
  logic [1:0]        id_branch_condition;
  logic [3:0]        id_alucontrol;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc_plus4;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [4:0]        id_shamt;
  logic              flush_i;
  logic              hold_i;

  logic              ex_regwrite;
  logic              ex_memtoreg;
  logic              ex_memwrite;
  logic              ex_alusrc;
  logic              ex_regdst;
  logic              ex_jump;
  logic              ex_branch;
  logic [1:0]        ex_branch_condition;
  logic [3:0]        ex_alucontrol;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_pc_plus4;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic [4:0]        ex_shamt;
  logic [REG_AW-1:0] ex_wreg;
  logic              ex_valid;
  logic              stall_o;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_regwrite, id_memtoreg, id_memwrite, id_alusrc, id_regdst, id_jump,
           id_branch, id_branch_condition, id_alucontrol, id_use_rs, id_use_rt,
           id_rd1, id_rd2, id_imm, id_pc_plus4, id_rs, id_rt, id_rd, id_shamt,
           flush_i, hold_i,
    input  ex_regwrite, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regdst, ex_jump,
           ex_branch, ex_branch_condition, ex_alucontrol, ex_rd1, ex_rd2, ex_imm,
           ex_pc_plus4, ex_rs, ex_rt, ex_rd, ex_shamt, ex_wreg, ex_valid,
           stall_o, bubble_cnt
  );

  modport slave (
    input  id_regwrite, id_memtoreg, id_memwrite, id_alusrc, id_regdst, id_jump,
           id_branch, id_branch_condition, id_alucontrol, id_use_rs, id_use_rt,
           id_rd1, id_rd2, id_imm, id_pc_plus4, id_rs, id_rt, id_rd, id_shamt,
           flush_i, hold_i,
    output ex_regwrite, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regdst, ex_jump,
           ex_branch, ex_branch_condition, ex_alucontrol, ex_rd1, ex_rd2, ex_imm,
           ex_pc_plus4, ex_rs, ex_rt, ex_rd, ex_shamt, ex_wreg, ex_valid,
           stall_o, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control
// and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  id_ex_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [REG_AW-1:0] id_wreg_c;
  logic              lu_c;
  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q, pc_plus4_q;

  assign id_wreg_c = bus.id_regdst ? bus.id_rd : bus.id_rt;

  // Load in EX whose destination is read by the instruction in ID
  always_comb begin
    lu_c = 1'b0;
    if (bus.ex_valid && bus.ex_memtoreg && bus.ex_regwrite && (bus.ex_wreg != '0)) begin
      lu_c = (bus.id_use_rs && (bus.id_rs == bus.ex_wreg)) ||
             (bus.id_use_rt && (bus.id_rt == bus.ex_wreg));
    end
  end

  assign bus.stall_o = lu_c & ~bus.flush_i;

  assign bus.ex_rd1      = rd1_q;
  assign bus.ex_rd2      = rd2_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_pc_plus4 = pc_plus4_q;

  // Data fields follow ID on every non-held edge, bubbles and flushes included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      pc_plus4_q   <= '0;
      bus.ex_rs    <= '0;
      bus.ex_rt    <= '0;
      bus.ex_rd    <= '0;
      bus.ex_shamt <= '0;
      bus.ex_wreg  <= '0;
    end else if (bus.flush_i || !bus.hold_i) begin
      rd1_q        <= bus.id_rd1;
      rd2_q        <= bus.id_rd2;
      imm_q        <= bus.id_imm;
      pc_plus4_q   <= bus.id_pc_plus4;
      bus.ex_rs    <= bus.id_rs;
      bus.ex_rt    <= bus.id_rt;
      bus.ex_rd    <= bus.id_rd;
      bus.ex_shamt <= bus.id_shamt;
      bus.ex_wreg  <= id_wreg_c;
    end
  end

  // Control, valid and counter: flush > hold > load-use bubble > capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_regwrite         <= 1'b0;
      bus.ex_memtoreg         <= 1'b0;
      bus.ex_memwrite         <= 1'b0;
      bus.ex_alusrc           <= 1'b0;
      bus.ex_regdst           <= 1'b0;
      bus.ex_jump             <= 1'b0;
      bus.ex_branch           <= 1'b0;
      bus.ex_branch_condition <= 2'b00;
      bus.ex_alucontrol       <= 4'h0;
      bus.ex_valid            <= 1'b0;
      bus.bubble_cnt          <= '0;
    end else if (bus.flush_i || (!bus.hold_i && lu_c)) begin
      bus.ex_regwrite         <= 1'b0;
      bus.ex_memtoreg         <= 1'b0;
      bus.ex_memwrite         <= 1'b0;
      bus.ex_alusrc           <= 1'b0;
      bus.ex_regdst           <= 1'b0;
      bus.ex_jump             <= 1'b0;
      bus.ex_branch           <= 1'b0;
      bus.ex_branch_condition <= 2'b00;
      bus.ex_alucontrol       <= 4'h0;
      bus.ex_valid            <= 1'b0;
      if (!bus.flush_i && (bus.bubble_cnt != CNT_MAX)) begin
        bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
      end
    end else if (!bus.hold_i) begin
      bus.ex_regwrite         <= bus.id_regwrite;
      bus.ex_memtoreg         <= bus.id_memtoreg;
      bus.ex_memwrite         <= bus.id_memwrite;
      bus.ex_alusrc           <= bus.id_alusrc;
      bus.ex_regdst           <= bus.id_regdst;
      bus.ex_jump             <= bus.id_jump;
      bus.ex_branch           <= bus.id_branch;
      bus.ex_branch_condition <= bus.id_branch_condition;
      bus.ex_alucontrol       <= bus.id_alucontrol;
      bus.ex_valid            <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// checked against a transaction-level model of the EX latch.
module tb_id_ex_stage;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 8;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  id_ex_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus ();

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of what EX should contain
  logic [12:0]  m_ctrl;
  logic         m_valid;
  int           m_cnt;
  logic [152:0] m_data;
  bit           m_known;

  function automatic logic [12:0] id_ctrl();
    return {bus.id_regwrite, bus.id_memtoreg, bus.id_memwrite, bus.id_alusrc,
            bus.id_regdst, bus.id_jump, bus.id_branch, bus.id_branch_condition,
            bus.id_alucontrol};
  endfunction

  function automatic logic [152:0] id_data();
    logic [4:0] dst;
    dst = bus.id_regdst ? bus.id_rd : bus.id_rt;
    return {bus.id_rd1, bus.id_rd2, bus.id_imm, bus.id_pc_plus4,
            bus.id_rs, bus.id_rt, bus.id_rd, bus.id_shamt, dst};
  endfunction

  function automatic logic [21:0] obs_ctrl();
    return {bus.ex_regwrite, bus.ex_memtoreg, bus.ex_memwrite, bus.ex_alusrc,
            bus.ex_regdst, bus.ex_jump, bus.ex_branch, bus.ex_branch_condition,
            bus.ex_alucontrol, bus.ex_valid, bus.bubble_cnt};
  endfunction

  function automatic logic [152:0] obs_data();
    return {bus.ex_rd1, bus.ex_rd2, bus.ex_imm, bus.ex_pc_plus4,
            bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_shamt, bus.ex_wreg};
  endfunction

  function automatic logic [21:0] exp_ctrl();
    return {m_ctrl, m_valid, CW'(m_cnt)};
  endfunction

  // Hazard rule: a valid load in EX writing a nonzero register that ID reads
  function automatic logic model_lu();
    logic [4:0] w;
    w = m_data[4:0];
    if (!(m_valid && m_ctrl[12] && m_ctrl[11] && w != 5'd0)) return 1'b0;
    return (bus.id_use_rs && bus.id_rs == w) || (bus.id_use_rt && bus.id_rt == w);
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_valid = 1'b0; m_cnt = 0; m_data = '0; m_known = 1'b1;
  endtask

  task automatic step();
    logic lu;
    logic [12:0] c;
    logic [152:0] d;
    lu = model_lu();
    c  = id_ctrl();
    d  = id_data();
    @(posedge clk);
    if (bus.flush_i) begin
      m_ctrl = '0; m_valid = 1'b0; m_known = 1'b0;
    end else if (bus.hold_i) begin
      // EX frozen
    end else if (lu) begin
      m_ctrl = '0; m_valid = 1'b0; m_data = d; m_known = 1'b1;
      if (m_cnt < CMAX) m_cnt++;
    end else begin
      m_ctrl = c; m_valid = 1'b1; m_data = d; m_known = 1'b1;
    end
    #1;
  endtask

  task automatic drive_random();
    bus.id_regwrite         = 1'($urandom);
    bus.id_memtoreg         = 1'($urandom);
    bus.id_memwrite         = 1'($urandom);
    bus.id_alusrc           = 1'($urandom);
    bus.id_regdst           = 1'($urandom);
    bus.id_jump             = 1'($urandom);
    bus.id_branch           = 1'($urandom);
    bus.id_branch_condition = 2'($urandom);
    bus.id_alucontrol       = 4'($urandom);
    bus.id_use_rs           = 1'($urandom);
    bus.id_use_rt           = 1'($urandom);
    bus.id_rd1              = $urandom;
    bus.id_rd2              = $urandom;
    bus.id_imm              = $urandom;
    bus.id_pc_plus4         = $urandom;
    bus.id_rs               = 5'($urandom_range(0, 3));
    bus.id_rt               = 5'($urandom_range(0, 3));
    bus.id_rd               = 5'($urandom_range(0, 3));
    bus.id_shamt            = 5'($urandom);
    bus.flush_i             = ($urandom_range(0, 9) == 0);
    bus.hold_i              = ($urandom_range(0, 7) == 0);
  endtask

  task automatic set_instr(input bit rw, input bit mtr, input bit rdst,
                           input int rs, input int rt, input int rd,
                           input bit urs, input bit urt);
    drive_random();
    bus.id_regwrite = rw;
    bus.id_memtoreg = mtr;
    bus.id_memwrite = 1'b0;
    bus.id_regdst   = rdst;
    bus.id_rs       = 5'(rs);
    bus.id_rt       = 5'(rt);
    bus.id_rd       = 5'(rd);
    bus.id_use_rs   = urs;
    bus.id_use_rt   = urt;
    bus.flush_i     = 1'b0;
    bus.hold_i      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_random();
    #2;
    checks++;
    if (obs_ctrl() !== 22'd0) begin
      errors++; $display("FAIL reset_ctrl got=%h exp=0", obs_ctrl());
    end
    checks++;
    if (obs_data() !== 153'd0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", obs_data());
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall_o);
    end
    model_reset();
    rst_n = 1'b1;
    set_instr(1, 0, 1, 1, 2, 3, 1, 1);
    step();
    checks++;
    if (bus.ex_valid !== 1'b1 || obs_ctrl() !== exp_ctrl() || obs_data() !== m_data) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", obs_ctrl(), exp_ctrl());
    end
  endtask

  task automatic test_pass_through();
    set_instr(1, 0, 1, 1, 2, 3, 1, 1);
    bus.id_rd1 = 32'h11;
    bus.id_rd2 = 32'h22;
    bus.id_alucontrol = 4'h2;
    step();
    checks++;
    if (bus.ex_rd1 !== 32'h11 || bus.ex_rd2 !== 32'h22 || bus.ex_wreg !== 5'd3 ||
        bus.ex_regwrite !== 1'b1 || bus.ex_alucontrol !== 4'h2 || bus.ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL pass_through got rd1=%h rd2=%h wreg=%0d rw=%b alu=%h v=%b exp 11 22 3 1 2 1",
               bus.ex_rd1, bus.ex_rd2, bus.ex_wreg, bus.ex_regwrite, bus.ex_alucontrol, bus.ex_valid);
    end
  endtask

  task automatic test_load_use();
    int c0;
    set_instr(1, 1, 0, 2, 5, 9, 1, 0);   // lw $5
    step();
    c0 = m_cnt;
    set_instr(1, 0, 1, 5, 1, 6, 1, 1);   // add $6,$5,$1
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL lu_stall got=%b exp=1", bus.stall_o);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_regwrite !== 1'b0 || bus.ex_memwrite !== 1'b0 ||
        obs_ctrl() !== {21'd0, 1'b0} + 22'(c0 + 1)) begin
      errors++; $display("FAIL lu_bubble got=%h exp_cnt=%0d", obs_ctrl(), c0 + 1);
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL lu_one_cycle got=%b exp=0", bus.stall_o);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_wreg !== 5'd6 || bus.ex_regwrite !== 1'b1) begin
      errors++; $display("FAIL lu_advance got v=%b wreg=%0d exp v=1 wreg=6", bus.ex_valid, bus.ex_wreg);
    end
  endtask

  task automatic test_no_false_stall();
    int c0;
    c0 = m_cnt;
    set_instr(1, 1, 0, 2, 0, 9, 1, 0);   // lw $0
    step();
    set_instr(1, 0, 1, 0, 0, 6, 1, 1);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL nostall_r0 got=%b exp=0", bus.stall_o);
    end
    set_instr(1, 1, 0, 2, 5, 9, 1, 0);   // lw $5
    step();
    set_instr(1, 0, 0, 1, 5, 4, 1, 0);   // rt=5 present but not read
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL nostall_use_rt got=%b exp=0", bus.stall_o);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b1 || int'(bus.bubble_cnt) !== c0) begin
      errors++; $display("FAIL nostall_capture got v=%b cnt=%0d exp v=1 cnt=%0d",
                         bus.ex_valid, bus.bubble_cnt, c0);
    end
  endtask

  task automatic test_flush_priority();
    int c0;
    for (int k = 0; k < 2; k++) begin
      set_instr(1, 1, 0, 2, 5, 9, 1, 0);
      step();
      c0 = m_cnt;
      set_instr(1, 0, 1, 5, 1, 6, 1, 1);
      bus.flush_i = 1'b1;
      bus.hold_i  = (k == 1);
      #1;
      checks++;
      if (bus.stall_o !== 1'b0) begin
        errors++; $display("FAIL flush_stall k=%0d got=%b exp=0", k, bus.stall_o);
      end
      step();
      checks++;
      if (obs_ctrl() !== {21'd0, 1'b0} + 22'(c0)) begin
        errors++; $display("FAIL flush_bubble k=%0d got=%h exp_cnt=%0d", k, obs_ctrl(), c0);
      end
    end
  endtask

  task automatic test_hold();
    set_instr(1, 1, 0, 2, 5, 9, 1, 0);   // lw $5 into EX
    step();
    for (int k = 0; k < 3; k++) begin
      drive_random();
      bus.id_use_rs = 1'b1;
      bus.id_rs     = 5'd5;
      bus.flush_i   = 1'b0;
      bus.hold_i    = 1'b1;
      #1;
      checks++;
      if (bus.stall_o !== 1'b1) begin
        errors++; $display("FAIL hold_stall k=%0d got=%b exp=1", k, bus.stall_o);
      end
      step();
      checks++;
      if (obs_ctrl() !== exp_ctrl() || obs_data() !== m_data || bus.ex_wreg !== 5'd5) begin
        errors++; $display("FAIL hold_frozen k=%0d got=%h exp=%h", k, obs_ctrl(), exp_ctrl());
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    set_instr(1, 1, 0, 2, 7, 9, 1, 0);
    step();
    set_instr(1, 0, 1, 7, 1, 6, 1, 1);
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got=%b exp=1", bus.stall_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_ctrl() !== 22'd0 || obs_data() !== 153'd0 || bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL midrst_clear got=%h stall=%b exp=0", obs_ctrl(), bus.stall_o);
    end
    model_reset();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_random();
      #1;
      checks++;
      if (bus.stall_o !== (model_lu() & ~bus.flush_i)) begin
        errors++; $display("FAIL rand_stall i=%0d got=%b exp=%b", i, bus.stall_o,
                           model_lu() & ~bus.flush_i);
      end
      step();
      checks++;
      if (obs_ctrl() !== exp_ctrl()) begin
        errors++; $display("FAIL rand_ctrl i=%0d got=%h exp=%h", i, obs_ctrl(), exp_ctrl());
      end
      if (m_known) begin
        checks++;
        if (obs_data() !== m_data) begin
          errors++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, obs_data(), m_data);
        end
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CMAX + 4; i++) begin
      set_instr(1, 1, 0, 2, 7, 9, 1, 0);
      step();
      set_instr(1, 0, 1, 7, 1, 6, 1, 1);
      step();
      checks++;
      if (int'(bus.bubble_cnt) !== m_cnt) begin
        errors++; $display("FAIL sat_count i=%0d got=%0d exp=%0d", i, bus.bubble_cnt, m_cnt);
      end
    end
    checks++;
    if (bus.bubble_cnt !== CW'(CMAX)) begin
      errors++; $display("FAIL sat_final got=%0d exp=%0d", bus.bubble_cnt, CMAX);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.flush_i = 1'b0;
    bus.hold_i  = 1'b0;
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_false_stall();
    test_flush_priority();
    test_hold();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
